// File: rtl/gsm_pkg.sv
// Shared GSM definitions: FSM state encoding and default cell length,
// used by both the ingress requester and the egress side.
package gsm_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } gsm_state_e;

  localparam int GSM_CELL_WORDS = 8;

endpackage

// File: rtl/gsm_sync_fifo.sv
// Single-clock word FIFO with registered read data.
// The caller guarantees push only when not full and pop only when not empty.
// clr flushes pointers, fill and read data synchronously.
module gsm_sync_fifo #(
  parameter int DATA_W    = 256,
  parameter int DEPTH     = 32,
  parameter int LOG_DEPTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LOG_DEPTH:0] fill
);

  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1'b1);
  localparam logic [LOG_DEPTH:0]   FILL_ONE = (LOG_DEPTH+1)'(1'b1);

  logic [DATA_W-1:0]    mem_r [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_r;
  logic [LOG_DEPTH-1:0] rd_ptr_r;
  logic [LOG_DEPTH:0]   fill_r;
  logic [DATA_W-1:0]    rd_data_r;

  // Storage array write; the array itself needs no reset
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, fill level and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {LOG_DEPTH{1'b0}};
      rd_ptr_r  <= {LOG_DEPTH{1'b0}};
      fill_r    <= {(LOG_DEPTH+1){1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r  <= {LOG_DEPTH{1'b0}};
      rd_ptr_r  <= {LOG_DEPTH{1'b0}};
      fill_r    <= {(LOG_DEPTH+1){1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_data_r <= mem_r[rd_ptr_r];
      end
      case ({push, pop})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

  assign rd_data = rd_data_r;
  assign fill    = fill_r;

endmodule

// File: rtl/gsm_ingress_req.sv
// Ingress requester for one GSM switch input port.
// Buffers cells, requests the round-robin scheduler when a whole cell is held,
// and streams the granted cell into the shared-memory write port.
// Optional wait statistics are built only when GSM_REQ_WAIT_STATS_EN is defined;
// otherwise wait_cur/wait_max are tied to zero.
module gsm_ingress_req
  import gsm_pkg::*;
#(
  parameter int DATA_W         = 256,
  parameter int CELL_WORDS     = GSM_CELL_WORDS,
  parameter int FIFO_DEPTH     = 32,
  parameter int LOG_FIFO_DEPTH = 5,
  parameter int STAT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    req,
  input  logic                    grant,
  input  logic                    stall,
  output logic                    mem_wr_en,
  output logic [DATA_W-1:0]       mem_wr_data,
  output logic                    mem_wr_last,
  output logic [LOG_FIFO_DEPTH:0] cells_avail,
  output logic [STAT_W-1:0]       wait_cur,
  output logic [STAT_W-1:0]       wait_max
);

  localparam int IDX_W = $clog2(CELL_WORDS);
  localparam int CNT_W = $clog2(CELL_WORDS + 1);
  localparam logic [IDX_W-1:0]        IDX_ONE    = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(CELL_WORDS - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(CELL_WORDS - 1);
  localparam logic [CNT_W-1:0]        CNT_FULL   = CNT_W'(CELL_WORDS);
  localparam logic [LOG_FIFO_DEPTH:0] FILL_FULL  = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG_FIFO_DEPTH:0] CELLS_ZERO = {(LOG_FIFO_DEPTH+1){1'b0}};
  localparam logic [LOG_FIFO_DEPTH:0] CELLS_ONE  = (LOG_FIFO_DEPTH+1)'(1'b1);

  gsm_state_e              state_r;
  gsm_state_e              state_nxt_s;
  logic [IDX_W-1:0]        word_idx_r;
  logic [CNT_W-1:0]        xfer_cnt_r;
  logic [LOG_FIFO_DEPTH:0] cells_avail_r;
  logic [LOG_FIFO_DEPTH:0] fill_s;
  logic [DATA_W-1:0]       rd_data_s;
  logic                    in_ready_s;
  logic                    push_s;
  logic                    cell_done_s;
  logic                    req_s;
  logic                    accept_s;
  logic                    pop_s;
  logic                    last_s;
  logic                    mem_wr_en_r;
  logic                    mem_wr_last_r;

  // Full check uses the registered fill, so a full FIFO refuses a push even while popping
  assign in_ready_s  = (fill_s != FILL_FULL);
  assign push_s      = in_valid && in_ready_s && !clr;
  assign cell_done_s = push_s && (word_idx_r == IDX_LAST);

  gsm_sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (FIFO_DEPTH),
    .LOG_DEPTH(LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .push   (push_s),
    .pop    (pop_s),
    .wr_data(in_data),
    .rd_data(rd_data_s),
    .fill   (fill_s)
  );

  // FSM state register; clr returns to arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
    end else if (clr) begin
      state_r <= ARB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave XFER once all cell words have been popped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB: begin
        if (accept_s) begin
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = ARB;
        end
      end
      XFER: begin
        if (xfer_cnt_r == CNT_FULL) begin
          state_nxt_s = ARB;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: state_nxt_s = ARB;
    endcase
  end

  // FSM outputs: request, accept, and one FIFO pop per cycle from accept onward
  always_comb begin
    req_s    = 1'b0;
    accept_s = 1'b0;
    pop_s    = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ARB: begin
        req_s    = (cells_avail_r != CELLS_ZERO);
        accept_s = req_s && grant && !stall && !clr;
        pop_s    = accept_s;
        last_s   = 1'b0;
      end
      XFER: begin
        pop_s  = (xfer_cnt_r != CNT_FULL) && !clr;
        last_s = (xfer_cnt_r == CNT_LAST);
      end
      default: begin
        req_s  = 1'b0;
        pop_s  = 1'b0;
        last_s = 1'b0;
      end
    endcase
  end

  // Word position inside the ingress cell and pop count inside the egress burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_r <= {IDX_W{1'b0}};
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      word_idx_r <= {IDX_W{1'b0}};
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        word_idx_r <= (word_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (word_idx_r + IDX_ONE);
      end
      if (accept_s) begin
        xfer_cnt_r <= CNT_ONE;
      end else if (pop_s) begin
        xfer_cnt_r <= xfer_cnt_r + CNT_ONE;
      end
    end
  end

  // Complete-cell count; a completion and an accept in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_avail_r <= CELLS_ZERO;
    end else if (clr) begin
      cells_avail_r <= CELLS_ZERO;
    end else begin
      case ({cell_done_s, accept_s})
        2'b10:   cells_avail_r <= cells_avail_r + CELLS_ONE;
        2'b01:   cells_avail_r <= cells_avail_r - CELLS_ONE;
        default: cells_avail_r <= cells_avail_r;
      endcase
    end
  end

  // Registered write strobes; data comes straight from the FIFO read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en_r   <= 1'b0;
      mem_wr_last_r <= 1'b0;
    end else if (clr) begin
      mem_wr_en_r   <= 1'b0;
      mem_wr_last_r <= 1'b0;
    end else begin
      mem_wr_en_r   <= pop_s;
      mem_wr_last_r <= pop_s && last_s;
    end
  end

`ifdef GSM_REQ_WAIT_STATS_EN
  logic [STAT_W-1:0] wait_cur_r;
  logic [STAT_W-1:0] wait_max_r;

  // Saturating wait counter and running maximum sampled at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cur_r <= {STAT_W{1'b0}};
      wait_max_r <= {STAT_W{1'b0}};
    end else if (clr) begin
      wait_cur_r <= {STAT_W{1'b0}};
      wait_max_r <= {STAT_W{1'b0}};
    end else if (accept_s) begin
      wait_cur_r <= {STAT_W{1'b0}};
      wait_max_r <= (wait_cur_r > wait_max_r) ? wait_cur_r : wait_max_r;
    end else if (req_s && (wait_cur_r != {STAT_W{1'b1}})) begin
      wait_cur_r <= wait_cur_r + STAT_W'(1'b1);
    end else begin
      wait_cur_r <= wait_cur_r;
    end
  end

  assign wait_cur = wait_cur_r;
  assign wait_max = wait_max_r;
`else
  assign wait_cur = {STAT_W{1'b0}};
  assign wait_max = {STAT_W{1'b0}};
`endif

  assign in_ready    = in_ready_s;
  assign req         = req_s;
  assign mem_wr_en   = mem_wr_en_r;
  assign mem_wr_last = mem_wr_last_r;
  assign mem_wr_data = rd_data_s;
  assign cells_avail = cells_avail_r;

endmodule

// File: tb/tb_gsm_ingress_req.sv
// Self-checking bench for gsm_ingress_req: words pushed into the DUT are queued
// with their expected last flag and compared when the write port emits them.
module tb_gsm_ingress_req;

  localparam int DATA_W = 256;
  localparam int CW     = 8;
  localparam int LOGD   = 5;
  localparam int STAT_W = 16;
`ifdef GSM_REQ_WAIT_STATS_EN
  localparam int EXP_WAIT = 5;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              req;
  logic              grant;
  logic              grant_en;
  logic              stall;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_last;
  logic [LOGD:0]     cells_avail;
  logic [STAT_W-1:0] wait_cur;
  logic [STAT_W-1:0] wait_max;

  int   checks   = 0;
  int   failures = 0;
  int   tb_idx   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // scheduler model: grant follows req combinationally when enabled
  assign grant = grant_en & req;

  always #5 clk = ~clk;

  gsm_ingress_req dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .req        (req),
    .grant      (grant),
    .stall      (stall),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_wr_last(mem_wr_last),
    .cells_avail(cells_avail),
    .wait_cur   (wait_cur),
    .wait_max   (wait_max)
  );

  task automatic check_val(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkw(input logic [31:0] v);
    return {8{v}};
  endfunction

  task automatic push_word(input logic [31:0] v);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = mkw(v);
    e.d      = mkw(v);
    e.last   = (tb_idx == CW - 1);
    exp_q.push_back(e);
    tb_idx   = (tb_idx == CW - 1) ? 0 : tb_idx + 1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_word(base + 32'(i));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_drain_left"}, exp_q.size(), 0);
    @(negedge clk);
    check_val({tag, "_idle_en"}, mem_wr_en, 1'b0);
  endtask

  // write-port monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_wr", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_data", mem_wr_data, mon_e.d);
        check_val("wr_last", mem_wr_last, mon_e.last);
      end
    end else if (rst_n) begin
      check_val("last_without_en", mem_wr_last, 1'b0);
    end
  end

  initial begin : main
    logic [18:0] en_pat;
    logic [18:0] en_exp;
    logic [LOGD:0] ca0, ca1, ca10;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    stall = 1'b0; grant_en = 1'b0;
    en_pat = '0; en_exp = '0; ca0 = '0; ca1 = '0; ca10 = '0;

    // reset values
    #12;
    check_val("rst_req", req, 1'b0);
    check_val("rst_en", mem_wr_en, 1'b0);
    check_val("rst_last", mem_wr_last, 1'b0);
    check_val("rst_data", mem_wr_data, '0);
    check_val("rst_cells", cells_avail, '0);
    check_val("rst_wait_cur", wait_cur, '0);
    check_val("rst_wait_max", wait_max, '0);
    check_val("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: one cell, grant tied to req
    grant_en = 1'b1;
    push_words(32'h0, 8);
    @(negedge clk);
    check_val("t1_req", req, 1'b1);
    check_val("t1_cells", cells_avail, 1);
    drain("t1");
    check_val("t1_cells_end", cells_avail, 0);

    // 2: partial cell never requests
    push_words(32'h100, 7);
    idle(20);
    @(negedge clk);
    check_val("t2_req_partial", req, 1'b0);
    check_val("t2_cells_partial", cells_avail, 0);
    push_words(32'h107, 1);
    @(negedge clk);
    check_val("t2_req_full", req, 1'b1);
    drain("t2");

    // 4: stall blocks grant; wait statistics
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    stall = 1'b1;
    push_words(32'h200, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t4_req_stalled", req, 1'b1);
      check_val("t4_no_xfer", mem_wr_en, 1'b0);
      check_val("t4_wait_cur_ramp", wait_cur, (EXP_WAIT != 0) ? i : 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check_val("t4_wait_cur", wait_cur, EXP_WAIT);
    check_val("t4_en_accept_cycle", mem_wr_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t4_en_start", mem_wr_en, 1'b1);
    check_val("t4_wait_cur_clr", wait_cur, 0);
    check_val("t4_wait_max", wait_max, EXP_WAIT);
    drain("t4");

    // 3: two cells back to back, one idle cycle between bursts
    grant_en = 1'b0;
    push_words(32'h300, 16);
    @(negedge clk);
    check_val("t3_cells2", cells_avail, 2);
    check_val("t3_req", req, 1'b1);
    @(posedge clk); #1;
    grant_en = 1'b1;
    for (int s = 0; s < 19; s++) begin
      @(negedge clk);
      en_pat[s] = mem_wr_en;
      if (s == 0) ca0 = cells_avail;
      if (s == 1) ca1 = cells_avail;
      if (s == 10) ca10 = cells_avail;
      @(posedge clk); #1;
    end
    for (int s = 1; s <= 8; s++) en_exp[s] = 1'b1;
    for (int s = 10; s <= 17; s++) en_exp[s] = 1'b1;
    check_val("t3_burst_pattern", en_pat, en_exp);
    check_val("t3_cells_at_accept", ca0, 2);
    check_val("t3_cells_after1", ca1, 1);
    check_val("t3_cells_after2", ca10, 0);
    drain("t3");

    // 5: full FIFO refuses the 33rd word
    grant_en = 1'b0;
    push_words(32'h400, 32);
    @(negedge clk);
    check_val("t5_in_ready_full", in_ready, 1'b0);
    check_val("t5_cells4", cells_avail, 4);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = mkw(32'hBAD);
    @(negedge clk);
    check_val("t5_in_ready_refuse", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    grant_en = 1'b1;
    @(negedge clk);
    check_val("t5_in_ready_accept_cycle", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t5_in_ready_after_pop", in_ready, 1'b1);
    drain("t5");
    check_val("t5_cells_end", cells_avail, 0);

    // 6a: clr in the middle of a burst
    grant_en = 1'b0;
    push_words(32'h500, 11);
    @(posedge clk); #1;
    grant_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    tb_idx = 0;
    @(negedge clk);
    check_val("t6_clr_en", mem_wr_en, 1'b0);
    check_val("t6_clr_cells", cells_avail, 0);
    check_val("t6_clr_req", req, 1'b0);
    check_val("t6_clr_in_ready", in_ready, 1'b1);
    idle(12);
    push_words(32'h600, 8);
    drain("t6_clr");

    // 6b: asynchronous reset in the middle of a burst
    grant_en = 1'b0;
    push_words(32'h700, 11);
    @(posedge clk); #1;
    grant_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    tb_idx = 0;
    #1;
    check_val("t6_rst_en", mem_wr_en, 1'b0);
    check_val("t6_rst_cells", cells_avail, 0);
    check_val("t6_rst_req", req, 1'b0);
    check_val("t6_rst_data", mem_wr_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    push_words(32'h800, 8);
    drain("t6_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
